// File: rtl/systolic_is_sequencer.sv
// ---------------------------------------------------------------------------
// systolic_is_sequencer
//
// Control and streaming front-end for an input-stationary systolic array.
// One job is three phases:
//   LOAD    : ARRAY_WIDTH stationary input vectors go to the array (input_en).
//   COMPUTE : num_vectors weight vectors are streamed in (process_en).
//   DRAIN   : the array keeps stepping until every in-flight psum row has
//             been captured into the result register.
// Every weight vector sent into the array pushes a 1 into a tag pipe. That
// pipe is exactly as deep as the array latency and advances only on
// process_en cycles. When a 1 reaches the last stage, packed_psum_out holds
// that vector's psum row. If the result register cannot take a new row, the
// whole array is frozen (process_en low), so no row is ever dropped.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start, num_vectors    job start pulse (IDLE only) and weight vector count
//   busy, done            job in progress / one-cycle end-of-job pulse
//   in_valid/in_ready     input-vector stream, payload in_data
//   w_valid/w_ready       weight-vector stream, payload w_data
//   process_en, input_en  array enables
//   packed_input_in       input vector to the array
//   packed_weight_in      weight vector to the array
//   packed_psum_out       unskewed psum row from the array
//   res_valid/res_ready   result stream, payload res_data (registered)
// ---------------------------------------------------------------------------
module systolic_is_sequencer #(
  parameter int INPUT_WIDTH  = 16,
  parameter int WEIGHT_WIDTH = 16,
  parameter int PSUM_WIDTH   = 16,
  parameter int ARRAY_HEIGHT = 4,
  parameter int ARRAY_WIDTH  = 4,
  parameter int OUT_LATENCY  = ARRAY_HEIGHT + ARRAY_WIDTH,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [CNT_WIDTH-1:0]                 num_vectors,
  output logic                                 busy,
  output logic                                 done,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [INPUT_WIDTH*ARRAY_HEIGHT-1:0]  in_data,
  input  logic                                 w_valid,
  output logic                                 w_ready,
  input  logic [WEIGHT_WIDTH*ARRAY_WIDTH-1:0]  w_data,
  output logic                                 process_en,
  output logic                                 input_en,
  output logic [INPUT_WIDTH*ARRAY_HEIGHT-1:0]  packed_input_in,
  output logic [WEIGHT_WIDTH*ARRAY_WIDTH-1:0]  packed_weight_in,
  input  logic [PSUM_WIDTH*ARRAY_HEIGHT-1:0]   packed_psum_out,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic [PSUM_WIDTH*ARRAY_HEIGHT-1:0]   res_data
);

  // Load counter only needs to count 0 .. ARRAY_WIDTH-1.
  localparam int LOAD_CW = (ARRAY_WIDTH > 1) ? $clog2(ARRAY_WIDTH) : 1;
  localparam logic [LOAD_CW-1:0] LOAD_LAST = LOAD_CW'(ARRAY_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  state_t                              state_reg;
  logic [LOAD_CW-1:0]                  load_cnt_reg;
  logic [CNT_WIDTH-1:0]                num_reg;
  logic [CNT_WIDTH-1:0]                vec_cnt_reg;
  logic [OUT_LATENCY-1:0]              tag_reg;
  logic [OUT_LATENCY-1:0]              tag_next;
  logic                                res_valid_reg;
  logic [PSUM_WIDTH*ARRAY_HEIGHT-1:0]  res_data_reg;

  logic can_adv;
  logic in_fire;
  logic w_fire;
  logic tag_empty;
  logic capture;
  logic last_vec;
  logic drain_done;
  logic in_load;

  // -------------------------------------------------------------------------
  // Handshake and enable decode
  // -------------------------------------------------------------------------
  // The result register can take a new row if it is empty or is being popped.
  assign can_adv   = !res_valid_reg || res_ready;
  assign in_load   = (state_reg == ST_LOAD);
  assign in_fire   = in_load && in_valid;
  assign w_fire    = (state_reg == ST_COMPUTE) && w_valid && can_adv;
  assign tag_empty = ~|tag_reg;

  // In DRAIN the array only needs to step while a real row is still in flight.
  assign process_en = w_fire ||
                      ((state_reg == ST_DRAIN) && !tag_empty && can_adv);

  // A row is taken only on an enabled cycle. That cycle already implies
  // can_adv, so the result register is never overwritten while still full.
  assign capture = process_en && tag_reg[OUT_LATENCY-1];

  // num_reg is at least 1 whenever COMPUTE is entered, so num_reg-1 is safe.
  assign last_vec   = (vec_cnt_reg == (num_reg - CNT_WIDTH'(1)));
  assign drain_done = (state_reg == ST_DRAIN) && tag_empty && !res_valid_reg;

  assign busy      = (state_reg != ST_IDLE);
  assign done      = drain_done;
  assign in_ready  = in_load;
  assign w_ready   = (state_reg == ST_COMPUTE) && can_adv;
  assign input_en  = in_fire;
  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;

  // -------------------------------------------------------------------------
  // Array data lanes: pass-through while in use, forced to zero otherwise so
  // the array never sees stale operands.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < ARRAY_HEIGHT; gi++) begin : g_in_lane
      assign packed_input_in[gi*INPUT_WIDTH +: INPUT_WIDTH] =
        in_load ? in_data[gi*INPUT_WIDTH +: INPUT_WIDTH] : '0;
    end

    for (gi = 0; gi < ARRAY_WIDTH; gi++) begin : g_w_lane
      assign packed_weight_in[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH] =
        w_fire ? w_data[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH] : '0;
    end

    // Tag pipe: stage 0 takes 1 for an accepted weight vector and 0 for a
    // drain bubble. The pipe holds its contents when the array is frozen.
    for (gi = 0; gi < OUT_LATENCY; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        assign tag_next[gi] = process_en ? w_fire : tag_reg[gi];
      end else begin : g_shift
        assign tag_next[gi] = process_en ? tag_reg[gi-1] : tag_reg[gi];
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Job FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      load_cnt_reg <= '0;
      vec_cnt_reg  <= '0;
      num_reg      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            num_reg      <= num_vectors;
            load_cnt_reg <= '0;
            vec_cnt_reg  <= '0;
            state_reg    <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (in_fire) begin
            if (load_cnt_reg == LOAD_LAST) begin
              load_cnt_reg <= '0;
              // An empty job skips straight to the end-of-job check.
              state_reg    <= (num_reg == '0) ? ST_DRAIN : ST_COMPUTE;
            end else begin
              load_cnt_reg <= load_cnt_reg + LOAD_CW'(1);
            end
          end
        end

        ST_COMPUTE: begin
          if (w_fire) begin
            if (last_vec) begin
              vec_cnt_reg <= '0;
              state_reg   <= ST_DRAIN;
            end else begin
              vec_cnt_reg <= vec_cnt_reg + CNT_WIDTH'(1);
            end
          end
        end

        ST_DRAIN: begin
          if (drain_done) begin
            state_reg <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Tag pipe and result register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_reg       <= '0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
    end else begin
      tag_reg <= tag_next;
      // If a capture and a pop happen together, the register stays full
      // and holds the new row.
      if (capture) begin
        res_valid_reg <= 1'b1;
        res_data_reg  <= packed_psum_out;
      end else if (res_ready) begin
        res_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_systolic_is_sequencer.sv
// ---------------------------------------------------------------------------
// tb_systolic_is_sequencer
//
// Directed bench for systolic_is_sequencer with a 4x4 array. The array is
// stood in for by an 8-stage delay line that advances on process_en. Each
// stage holds the sum of the weight lanes, plus the lane index on each lane.
// Weight vector v (all lanes = v) therefore returns the row
// {4v+3, 4v+2, 4v+1, 4v}.
// ---------------------------------------------------------------------------
module tb_systolic_is_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_vectors = '0;
  logic        busy, done;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [63:0] w_data = '0;
  logic        process_en, input_en;
  logic [63:0] packed_input_in, packed_weight_in, packed_psum_out;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [63:0] res_data;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-job observations, filled in by do_job.
  int  n_in_en, n_pe, n_pe_after, n_done;
  int  hold_err, pe_err, pw_err, pi_err, stall_err, hold_cycles;
  bit  busy_first, busy_at_done, timed_out;
  logic [63:0] rx_q[$];

  always #5 clk = ~clk;

  systolic_is_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .num_vectors      (num_vectors),
    .busy             (busy),
    .done             (done),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .w_valid          (w_valid),
    .w_ready          (w_ready),
    .w_data           (w_data),
    .process_en       (process_en),
    .input_en         (input_en),
    .packed_input_in  (packed_input_in),
    .packed_weight_in (packed_weight_in),
    .packed_psum_out  (packed_psum_out),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data)
  );

  // Array stand-in: 8-enabled-cycle delay of the weight sum.
  logic [63:0] arr_pipe [8];
  logic [15:0] wsum;
  assign wsum = packed_weight_in[15:0] + packed_weight_in[31:16] +
                packed_weight_in[47:32] + packed_weight_in[63:48];
  assign packed_psum_out = arr_pipe[7];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) arr_pipe[i] <= '0;
    end else if (process_en) begin
      arr_pipe[0] <= {wsum + 16'd3, wsum + 16'd2, wsum + 16'd1, wsum};
      for (int i = 1; i < 8; i++) arr_pipe[i] <= arr_pipe[i-1];
    end
  end

  function automatic logic [63:0] exp_row(input int v);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[i*16 +: 16] = 16'(4 * v + i);
    return r;
  endfunction

  // Runs one job: start, 4 input loads, nvec weights (value wbase+k).
  // Inputs change 1ns after posedge; outputs are observed on negedge.
  task automatic do_job(input int nvec, input int wbase, input bit w_gaps,
                        input int stall_from, input int stall_len,
                        input bit start_in_drain, input int abort_w);
    int c, li, wi, post;
    bit seen_done, prev_hold, drain_start_done;
    logic [63:0] prev_data;
    rx_q.delete();
    n_in_en = 0; n_pe = 0; n_pe_after = 0; n_done = 0;
    hold_err = 0; pe_err = 0; pw_err = 0; pi_err = 0; stall_err = 0;
    hold_cycles = 0; busy_first = 0; busy_at_done = 0; timed_out = 0;
    @(posedge clk); #1;
    start = 1'b1; num_vectors = 16'(nvec);
    @(posedge clk); #1;
    start = 1'b0;
    c = 0; li = 0; wi = 0; post = 0;
    seen_done = 0; prev_hold = 0; drain_start_done = 0; prev_data = '0;
    forever begin
      in_valid = (li < 4);
      for (int i = 0; i < 4; i++) in_data[i*16 +: 16] = 16'(16 * li + i + 1);
      w_valid = (wi < nvec) && (!w_gaps || (c % 2 == 0));
      for (int i = 0; i < 4; i++) w_data[i*16 +: 16] = 16'(wbase + wi);
      res_ready = !(c >= stall_from && c < stall_from + stall_len);
      if (start_in_drain && nvec > 0 && wi == nvec && !drain_start_done) begin
        start = 1'b1;
        drain_start_done = 1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (c == 0) busy_first = busy;
      if (input_en) n_in_en++;
      if (input_en !== (in_valid && in_ready)) pi_err++;
      if (input_en && packed_input_in !== in_data) pi_err++;
      if (!in_ready && packed_input_in !== '0) pi_err++;
      if (process_en) begin
        n_pe++;
        if (wi == nvec) n_pe_after++;
      end
      if (wi < nvec && process_en !== (w_valid && w_ready)) pe_err++;
      if (process_en && wi < nvec) begin
        if (packed_weight_in !== w_data) pw_err++;
      end else if (packed_weight_in !== '0) begin
        pw_err++;
      end
      if (res_valid && !res_ready && process_en) stall_err++;
      if (prev_hold && (!res_valid || res_data !== prev_data)) hold_err++;
      prev_hold = res_valid && !res_ready;
      if (prev_hold) hold_cycles++;
      prev_data = res_data;
      if (res_valid && res_ready) rx_q.push_back(res_data);
      if (in_valid && in_ready) li++;
      if (w_valid && w_ready) wi++;
      if (done) begin
        n_done++;
        if (!seen_done) busy_at_done = busy;
        seen_done = 1;
      end
      if (abort_w > 0 && wi == abort_w) begin
        @(posedge clk); #1;
        break;
      end
      if (seen_done) post++;
      if (post > 3) break;
      c++;
      if (c > 600) begin
        timed_out = 1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; w_valid = 1'b0; res_ready = 1'b1; start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; w_valid = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_tests++; if ({busy, done, in_ready, w_ready, process_en, input_en, res_valid} !== 7'b0) begin n_fail++; $display("FAIL reset_ctrl got %b exp 0000000", {busy, done, in_ready, w_ready, process_en, input_en, res_valid}); end
    n_tests++; if (res_data !== 64'h0) begin n_fail++; $display("FAIL reset_res_data got %h exp 0", res_data); end
    n_tests++; if (packed_input_in !== 64'h0) begin n_fail++; $display("FAIL reset_input_in got %h exp 0", packed_input_in); end
    n_tests++; if (packed_weight_in !== 64'h0) begin n_fail++; $display("FAIL reset_weight_in got %h exp 0", packed_weight_in); end
    in_valid = 1'b0; w_valid = 1'b0;
    $display("[TB] test_reset done");
  endtask

  task automatic test_basic;
    do_job(3, 1, 0, -100, 0, 0, 0);
    n_tests++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL basic_timeout got %0d exp 0", timed_out); end
    n_tests++; if (busy_first !== 1'b1) begin n_fail++; $display("FAIL basic_busy_first got %0d exp 1", busy_first); end
    n_tests++; if (n_in_en != 4) begin n_fail++; $display("FAIL basic_input_en_cycles got %0d exp 4", n_in_en); end
    n_tests++; if (pi_err != 0) begin n_fail++; $display("FAIL basic_input_path got %0d errs exp 0", pi_err); end
    n_tests++; if (n_pe != 11) begin n_fail++; $display("FAIL basic_pe_cycles got %0d exp 11", n_pe); end
    n_tests++; if (n_pe_after != 8) begin n_fail++; $display("FAIL basic_drain_cycles got %0d exp 8", n_pe_after); end
    n_tests++; if (pw_err != 0) begin n_fail++; $display("FAIL basic_weight_path got %0d errs exp 0", pw_err); end
    n_tests++; if (rx_q.size() != 3) begin n_fail++; $display("FAIL basic_count got %0d exp 3", rx_q.size()); end
    for (int k = 0; k < rx_q.size() && k < 3; k++) begin
      n_tests++; if (rx_q[k] !== exp_row(1 + k)) begin n_fail++; $display("FAIL basic_row%0d got %h exp %h", k, rx_q[k], exp_row(1 + k)); end
    end
    n_tests++; if (n_done != 1) begin n_fail++; $display("FAIL basic_done_pulses got %0d exp 1", n_done); end
    n_tests++; if (busy_at_done !== 1'b1) begin n_fail++; $display("FAIL basic_busy_at_done got %0d exp 1", busy_at_done); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got %0d exp 0", busy); end
    $display("[TB] test_basic: %0d results, %0d enabled cycles", rx_q.size(), n_pe);
  endtask

  task automatic test_zero_vectors;
    do_job(0, 0, 0, -100, 0, 0, 0);
    n_tests++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL zero_timeout got %0d exp 0", timed_out); end
    n_tests++; if (n_in_en != 4) begin n_fail++; $display("FAIL zero_input_en_cycles got %0d exp 4", n_in_en); end
    n_tests++; if (n_pe != 0) begin n_fail++; $display("FAIL zero_pe_cycles got %0d exp 0", n_pe); end
    n_tests++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL zero_count got %0d exp 0", rx_q.size()); end
    n_tests++; if (n_done != 1) begin n_fail++; $display("FAIL zero_done_pulses got %0d exp 1", n_done); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_after got %0d exp 0", busy); end
    $display("[TB] test_zero_vectors: %0d results", rx_q.size());
  endtask

  task automatic test_backpressure;
    do_job(6, 10, 0, 8, 20, 0, 0);
    n_tests++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL bp_timeout got %0d exp 0", timed_out); end
    n_tests++; if ((hold_cycles > 0) !== 1'b1) begin n_fail++; $display("FAIL bp_hold_seen got %0d cycles exp >0", hold_cycles); end
    n_tests++; if (hold_err != 0) begin n_fail++; $display("FAIL bp_hold_stable got %0d errs exp 0", hold_err); end
    n_tests++; if (stall_err != 0) begin n_fail++; $display("FAIL bp_freeze got %0d errs exp 0", stall_err); end
    n_tests++; if (n_pe != 14) begin n_fail++; $display("FAIL bp_pe_cycles got %0d exp 14", n_pe); end
    n_tests++; if (rx_q.size() != 6) begin n_fail++; $display("FAIL bp_count got %0d exp 6", rx_q.size()); end
    for (int k = 0; k < rx_q.size() && k < 6; k++) begin
      n_tests++; if (rx_q[k] !== exp_row(10 + k)) begin n_fail++; $display("FAIL bp_row%0d got %h exp %h", k, rx_q[k], exp_row(10 + k)); end
    end
    n_tests++; if (n_done != 1) begin n_fail++; $display("FAIL bp_done_pulses got %0d exp 1", n_done); end
    $display("[TB] test_backpressure: %0d results, %0d held cycles", rx_q.size(), hold_cycles);
  endtask

  task automatic test_w_gaps;
    do_job(4, 20, 1, -100, 0, 0, 0);
    n_tests++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL gaps_timeout got %0d exp 0", timed_out); end
    n_tests++; if (pe_err != 0) begin n_fail++; $display("FAIL gaps_pe_follows got %0d errs exp 0", pe_err); end
    n_tests++; if (pw_err != 0) begin n_fail++; $display("FAIL gaps_weight_path got %0d errs exp 0", pw_err); end
    n_tests++; if (n_pe != 12) begin n_fail++; $display("FAIL gaps_pe_cycles got %0d exp 12", n_pe); end
    n_tests++; if (n_pe_after != 8) begin n_fail++; $display("FAIL gaps_drain_cycles got %0d exp 8", n_pe_after); end
    n_tests++; if (rx_q.size() != 4) begin n_fail++; $display("FAIL gaps_count got %0d exp 4", rx_q.size()); end
    for (int k = 0; k < rx_q.size() && k < 4; k++) begin
      n_tests++; if (rx_q[k] !== exp_row(20 + k)) begin n_fail++; $display("FAIL gaps_row%0d got %h exp %h", k, rx_q[k], exp_row(20 + k)); end
    end
    $display("[TB] test_w_gaps: %0d results, %0d enabled cycles", rx_q.size(), n_pe);
  endtask

  task automatic test_midjob_reset;
    do_job(5, 30, 0, -100, 0, 0, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++; if ({busy, done, in_ready, w_ready, process_en, input_en, res_valid} !== 7'b0) begin n_fail++; $display("FAIL midrst_ctrl got %b exp 0000000", {busy, done, in_ready, w_ready, process_en, input_en, res_valid}); end
    n_tests++; if (res_data !== 64'h0) begin n_fail++; $display("FAIL midrst_res_data got %h exp 0", res_data); end
    n_tests++; if (packed_weight_in !== 64'h0) begin n_fail++; $display("FAIL midrst_weight_in got %h exp 0", packed_weight_in); end
    rst = 1'b0;
    do_job(2, 40, 0, -100, 0, 0, 0);
    n_tests++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL midrst_timeout got %0d exp 0", timed_out); end
    n_tests++; if (rx_q.size() != 2) begin n_fail++; $display("FAIL midrst_count got %0d exp 2", rx_q.size()); end
    for (int k = 0; k < rx_q.size() && k < 2; k++) begin
      n_tests++; if (rx_q[k] !== exp_row(40 + k)) begin n_fail++; $display("FAIL midrst_row%0d got %h exp %h", k, rx_q[k], exp_row(40 + k)); end
    end
    n_tests++; if (n_done != 1) begin n_fail++; $display("FAIL midrst_done_pulses got %0d exp 1", n_done); end
    $display("[TB] test_midjob_reset: fresh job %0d results", rx_q.size());
  endtask

  task automatic test_start_in_drain;
    do_job(3, 50, 0, -100, 0, 1, 0);
    n_tests++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL drainstart_timeout got %0d exp 0", timed_out); end
    n_tests++; if (n_done != 1) begin n_fail++; $display("FAIL drainstart_done_pulses got %0d exp 1", n_done); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drainstart_busy_after got %0d exp 0", busy); end
    n_tests++; if (rx_q.size() != 3) begin n_fail++; $display("FAIL drainstart_count got %0d exp 3", rx_q.size()); end
    do_job(1, 60, 0, -100, 0, 0, 0);
    n_tests++; if (rx_q.size() != 1) begin n_fail++; $display("FAIL drainstart_next_count got %0d exp 1", rx_q.size()); end
    if (rx_q.size() > 0) begin
      n_tests++; if (rx_q[0] !== exp_row(60)) begin n_fail++; $display("FAIL drainstart_next_row got %h exp %h", rx_q[0], exp_row(60)); end
    end
    n_tests++; if (n_done != 1) begin n_fail++; $display("FAIL drainstart_next_done got %0d exp 1", n_done); end
    $display("[TB] test_start_in_drain: next job %0d results", rx_q.size());
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_vectors();
    test_backpressure();
    test_w_gaps();
    test_midjob_reset();
    test_start_in_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/systolic_is_sequencer.md
Name: systolic_is_sequencer

Overview:
- Control and streaming front-end for the input-stationary systolic array; sits between the on-chip buffers and the array.
- Per job: loads ARRAY_WIDTH stationary input vectors with input_en, streams NUM weight vectors with process_en, then drains the pipeline.
- Captures each unskewed psum row into a valid/ready result stream.
- Applies backpressure by freezing the whole array (process_en low), so no result is ever lost.

Parameters:
- INPUT_WIDTH, 16, bits per input element
- WEIGHT_WIDTH, 16, bits per weight element
- PSUM_WIDTH, 16, bits per psum element
- ARRAY_HEIGHT, 4, array rows (psum row length)
- ARRAY_WIDTH, 4, array columns (weight vector length)
- OUT_LATENCY, ARRAY_HEIGHT+ARRAY_WIDTH, enabled cycles from weight vector accept to its psum row on packed_psum_out (>=1)
- CNT_WIDTH, 16, width of job vector count

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  job start pulse; sampled only in IDLE
- num_vectors  in  CNT_WIDTH  weight vectors in the job; latched on start
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at job end
- in_valid / in_ready  in / out  1 / 1  input-vector stream handshake
- in_data  in  INPUT_WIDTH*ARRAY_HEIGHT  input vector
- w_valid / w_ready  in / out  1 / 1  weight-vector stream handshake
- w_data  in  WEIGHT_WIDTH*ARRAY_WIDTH  weight vector
- process_en  out  1  to array
- input_en  out  1  to array
- packed_input_in  out  INPUT_WIDTH*ARRAY_HEIGHT  to array
- packed_weight_in  out  WEIGHT_WIDTH*ARRAY_WIDTH  to array
- packed_psum_out  in  PSUM_WIDTH*ARRAY_HEIGHT  from array (unskewed)
- res_valid / res_ready  out / in  1 / 1  result stream handshake
- res_data  out  PSUM_WIDTH*ARRAY_HEIGHT  registered psum row

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- Reset values (also the required state after rst asserted mid-job, no partial completion): state IDLE, all counters 0, tag pipe 0, busy 0, done 0, res_valid 0, res_data 0, in_ready 0, w_ready 0, process_en 0, input_en 0, array data outputs 0.
- Handshake: transfer when valid&&ready at a rising edge. res_data is held stable while res_valid&&!res_ready.
- can_adv = !res_valid || res_ready.
- IDLE:
  - start=1 latches num_vectors and goes to LOAD.
  - start while busy is ignored.
- LOAD:
  - in_ready=1, input_en=in_valid, packed_input_in=in_data (combinational pass-through), process_en=0.
  - Count accepted vectors; after the ARRAY_WIDTH-th, go to COMPUTE (or DRAIN if num_vectors==0).
- COMPUTE:
  - w_ready=can_adv.
  - process_en = w_valid && can_adv; packed_weight_in=w_data when process_en, else 0.
  - Each accepted vector pushes tag 1 into an OUT_LATENCY-deep tag shift pipe.
  - After the num_vectors-th accept, go to DRAIN.
- DRAIN:
  - w_ready=0, packed_weight_in=0.
  - process_en=can_adv while any tag is set; each enabled cycle pushes tag 0.
  - When tag pipe is empty and res_valid=0: done=1 for one cycle, then IDLE.
- Tag pipe:
  - Shifts only on cycles with process_en=1; frozen otherwise (array is frozen too).
  - On a process_en cycle whose last tag stage is 1, packed_psum_out is sampled into res_data and res_valid is set.
- Output register:
  - A simultaneous pop (res_ready) and capture in the same cycle keeps res_valid=1 with new data.
  - Pop without capture clears res_valid.
- Ordering: results leave in weight-vector order; exactly num_vectors results per job.
- busy: 1 in LOAD/COMPUTE/DRAIN, 0 in IDLE.
- done: asserted with busy still 1 on that cycle.
- Counter: num_vectors up to 2^CNT_WIDTH-1 supported; no wrap within a job.

Test Plan:
- 4x4, OUT_LATENCY=8, array model = 8-enabled-cycle delay of weight sum. Load 4 inputs, 3 weights (1,2,3), res_ready=1 -> input_en high exactly 4 cycles; 3 results in order; done 8 enabled cycles after last weight accept.
- num_vectors=0 -> 4 input loads, no process_en, no res_valid, done pulse, busy back to 0.
- res_ready=0 for 20 cycles mid-job, 6 vectors -> process_en drops while res_valid held; res_data unchanged; all 6 results arrive unduplicated after release.
- w_valid toggled 1,0,1,0 -> process_en follows accepts only; tag pipe frozen on stalls; result timing counted in enabled cycles.
- rst asserted in COMPUTE after 2 vectors -> next cycle all outputs at reset values; a fresh job with 2 vectors completes correctly.
- start pulsed during DRAIN -> ignored; single done; next start in IDLE accepted.
